led_scanner: RTL and testbench

Parametrised successor to the single-LED bouncing display driver. It drives a WIDTH-bit LED bank with a one-hot or thermometer pattern that steps at a programmable rate. Four modes are supported: bounce, rotate-left, rotate-right and bar. It sits between the board LED pins and control logic, and gives the top level a step-rate prescaler, run/pause control and a sweep-complete pulse for sequencing.

---
 rtl/led_scanner.sv | 117 +++++++++++
 tb/tb_led_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scanner.sv
// led_scanner: WIDTH-bit LED scanner (bounce / rotate-left / rotate-right / bar) with step prescaler.
// Optional macro LED_BRIGHT_EN adds a brightness input and 16-step PWM gating of the LED bank.
module led_scanner #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
`ifdef LED_BRIGHT_EN
    input  logic [3:0]       brightness,
`endif
    output logic [WIDTH-1:0] LED,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             sweep_done
);

    typedef enum logic [1:0] {BOUNCE = 2'b00, ROT_L = 2'b01, ROT_R = 2'b10, BAR = 2'b11} mode_t;

    localparam logic [POS_W-1:0] PMAX  = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] PTURN = POS_W'(WIDTH - 2);

    logic [DIV_W-1:0] cnt;
    logic             tick;
    mode_t            mode_i;
    mode_t            mode_q;
    logic [POS_W-1:0] pos_n;
    logic             dir_n;
    logic             sw_n;
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] therm;
    logic [WIDTH-1:0] pattern;

    assign mode_i = mode_t'(mode);
    assign tick   = en && (cnt == div);

    // Next position/direction under the currently requested mode; only consumed on a tick.
    always_comb begin
        pos_n = pos;
        dir_n = dir;
        sw_n  = 1'b0;
        case (mode_i)
            ROT_L: begin
                pos_n = (pos == PMAX) ? '0 : pos + 1'b1;
                dir_n = 1'b0;
                sw_n  = (pos == PMAX);
            end
            ROT_R: begin
                pos_n = (pos == '0) ? PMAX : pos - 1'b1;
                dir_n = 1'b1;
                sw_n  = (pos == '0);
            end
            default: begin
                if (!dir) begin
                    pos_n = (pos == PMAX) ? PTURN : pos + 1'b1;
                    dir_n = (pos == PMAX);
                end else begin
                    pos_n = (pos == '0) ? POS_W'(1) : pos - 1'b1;
                    dir_n = (pos != '0);
                    sw_n  = (pos == '0);
                end
            end
        endcase
    end

    // Prescaler, pattern state and registered step/sweep pulses; the displayed mode follows the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            pos        <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            sweep_done <= 1'b0;
            mode_q     <= BOUNCE;
        end else begin
            step       <= tick;
            sweep_done <= tick && sw_n;
            if (en)
                cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                pos    <= pos_n;
                dir    <= dir_n;
                mode_q <= mode_i;
            end
        end
    end

    assign onehot = WIDTH'(1) << pos;

    for (genvar i = 0; i < WIDTH; i++) begin : g_therm
        assign therm[i] = (POS_W'(i) <= pos);
    end

    assign pattern = (mode_q == BAR) ? therm : onehot;

`ifdef LED_BRIGHT_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase counter, independent of en.
    always_ff @(posedge clk) begin
        if (rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign LED = pattern & {WIDTH{pwm_cnt < brightness}};
`else
    assign LED = pattern;
`endif

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed bench for led_scanner with a rule-level reference model (WIDTH=8 and WIDTH=5).
module tb_led_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [23:0] div = '0;
`ifdef LED_BRIGHT_EN
    logic [3:0]  brightness = 4'd15;
`endif
    logic [7:0]  led8;
    logic [4:0]  led5;
    logic [2:0]  pos8, pos5;
    logic        dir8, dir5, step8, step5, sw8, sw5;

    int n_pass = 0;
    int n_tot = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    led_scanner #(.WIDTH(8), .DIV_W(24)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
`ifdef LED_BRIGHT_EN
        .brightness(brightness),
`endif
        .LED(led8), .pos(pos8), .dir(dir8), .step(step8), .sweep_done(sw8)
    );

    led_scanner #(.WIDTH(5), .DIV_W(24)) u5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
`ifdef LED_BRIGHT_EN
        .brightness(brightness),
`endif
        .LED(led5), .pos(pos5), .dir(dir5), .step(step5), .sweep_done(sw5)
    );

    typedef struct {
        int         p;
        bit         d;
        bit         s;
        bit         t;
        logic [1:0] md;
    } mst_t;

    mst_t        m[2];
    int unsigned m_cnt;
    int          m_pwm;

    function automatic int wv(int j);
        return (j == 0) ? 8 : 5;
    endfunction

    function automatic mst_t rst_st();
        mst_t r;
        r.p = 0; r.d = 0; r.s = 0; r.t = 0; r.md = 2'b00;
        return r;
    endfunction

    function automatic mst_t idle(mst_t c);
        mst_t r = c;
        r.s = 0; r.t = 0;
        return r;
    endfunction

    // Advance one step: bouncing reflects off the ends, rotating wraps modulo w.
    function automatic mst_t adv(int w, mst_t c, logic [1:0] md);
        mst_t r = c;
        int q;
        r.t = 1; r.s = 0; r.md = md;
        if (md == 2'b01) begin
            r.p = (c.p + 1) % w; r.d = 0; r.s = (r.p == 0);
        end else if (md == 2'b10) begin
            r.p = (c.p + w - 1) % w; r.d = 1; r.s = (r.p == w - 1);
        end else begin
            q = c.d ? c.p - 1 : c.p + 1;
            if (q > w - 1) begin
                q = w - 2; r.d = 1;
            end else if (q < 0) begin
                q = 1; r.d = 0; r.s = 1;
            end
            r.p = q;
        end
        return r;
    endfunction

    function automatic logic [63:0] g(logic [63:0] v);
`ifdef LED_BRIGHT_EN
        if (!(m_pwm < int'(brightness))) return 64'd0;
`endif
        return v;
    endfunction

    function automatic logic [63:0] exp_led(mst_t c);
        logic [63:0] v;
        v = (c.md == 2'b11) ? ((64'd2 << c.p) - 64'd1) : (64'd1 << c.p);
        return g(v);
    endfunction

    // Reference model advances on the same edges as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) m[j] <= rst_st();
            m_cnt <= 0;
            m_pwm <= 0;
        end else begin
            m_pwm <= (m_pwm + 1) % 16;
            for (int j = 0; j < 2; j++) begin
                if (en && m_cnt == div) m[j] <= adv(wv(j), m[j], mode);
                else m[j] <= idle(m[j]);
            end
            if (en) m_cnt <= (m_cnt == div) ? 0 : (m_cnt + 1) % (1 << 24);
        end
    end

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("led8", led8, exp_led(m[0]));
            chk("pos8", pos8, m[0].p);
            chk("dir8", dir8, m[0].d);
            chk("step8", step8, m[0].t);
            chk("sweep8", sw8, m[0].s);
            chk("led5", led5, exp_led(m[1]));
            chk("pos5", pos5, m[1].p);
            chk("dir5", dir5, m[1].d);
            chk("step5", step5, m[1].t);
            chk("sweep5", sw5, m[1].s);
        end
    end

    logic [7:0] e2[16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                           8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] e5[10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h3F};
    int         e4[6]  = '{4, 3, 2, 1, 0, 4};

    initial begin
        @(negedge clk);
        // Reset held for two edges
        rst = 1'b1; mode = 2'b11;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_led8", led8, g(64'h01));
        chk("rst_pos8", pos8, 0);
        chk("rst_dir8", dir8, 0);
        chk("rst_step8", step8, 0);
        chk("rst_sweep8", sw8, 0);
        chk("rst_led5", led5, g(64'h01));

        // Bounce, div=0
        rst = 1'b0; mode = 2'b00; div = 0; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("bounce_led", led8, g(e2[i]));
            chk("bounce_model", exp_led(m[0]), g(e2[i]));
            chk("bounce_sweep", sw8, i == 15);
            chk("bounce_step", step8, i > 0);
        end

        // Prescaler div=3 with a 5-cycle pause mid-count
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; div = 3; mode = 2'b01; en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("presc_step", step8, (k == 4 || k == 8 || k == 17));
            if (k >= 8 && k <= 16) chk("presc_pos", pos8, 2);
            if (k == 10) en = 1'b0;
            if (k == 15) en = 1'b1;
        end
        chk("presc_resume_pos", pos8, 3);

        // Rotate-right on the non-power-of-2 instance
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode = 2'b10; div = 0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rotr5_pos", pos5, e4[i]);
            chk("rotr5_led", led5, g(64'd1 << e4[i]));
            chk("rotr5_sweep", sw5, (i == 0 || i == 5));
        end

        // Bar mode, then switch to rotate-left while descending at pos 5
        rst = 1'b1; mode = 2'b11;
        @(negedge clk);
        rst = 1'b0; div = 0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("bar_led", led8, g(e5[i]));
        end
        chk("bar_pos", pos8, 5);
        chk("bar_dir", dir8, 1);
        mode = 2'b01;
        @(negedge clk);
        chk("switch_led", led8, g(64'h40));
        chk("switch_dir", dir8, 0);
        chk("switch_pos", pos8, 6);

        // Synchronous reset mid-sweep at pos 6
        rst = 1'b1; mode = 2'b00;
        @(negedge clk);
        rst = 1'b0; div = 0; en = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_pos_before", pos8, 6);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pos", pos8, 0);
        chk("mid_rst_step", step8, 0);
        chk("mid_rst_led", led8, g(64'h01));
        rst = 1'b0; en = 1'b0;

`ifdef LED_BRIGHT_EN
        begin
            int hi;
            hi = 0;
            brightness = 4'd4;
            repeat (16) begin
                @(negedge clk);
                if (led8[0]) hi++;
            end
            chk("bright4_duty", hi, 4);
            hi = 0;
            brightness = 4'd0;
            repeat (16) begin
                @(negedge clk);
                if (led8 != 8'h00) hi++;
            end
            chk("bright0_off", hi, 0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
